// File: rtl/conv_acc_pkg.sv
// Shared types and constants for the convolution accumulate scheduler.
package conv_acc_pkg;
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_e;

  localparam int TREE_W = 20;

  // Room for up to 2^CH_W - 1 full-scale tree results without wrap.
  localparam int ACC_W_HEADROOM = TREE_W;

  function automatic bit acc_w_ok(input int acc_w, input int ch_w);
    return acc_w >= ACC_W_HEADROOM + ch_w;
  endfunction
endpackage

// File: rtl/acc_out_fifo.sv
// First-word-fall-through output FIFO; push and pop may coincide even when full.
module acc_out_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [W-1:0]  mem_q [DEPTH];
  logic [PW-1:0] wr_q, rd_q;
  logic [CW-1:0] cnt_q;
  logic          do_push, do_pop;

  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty_o = (cnt_q == '0);
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = mem_q[rd_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      if (do_push) begin
        mem_q[wr_q] <= wdata_i;
        wr_q        <= nxt(wr_q);
      end
      if (do_pop) rd_q <= nxt(rd_q);
      cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
    end
  end
endmodule

// File: rtl/conv_acc_sched.sv
// Job scheduler around the adder tree: gates launches, sums num_ch results per pixel, queues pixel sums.
module conv_acc_sched
  import conv_acc_pkg::*;
#(
  parameter int TREE_LAT  = 4,
  parameter int CH_W      = 8,
  parameter int OUT_W     = 16,
  parameter int ACC_W     = 32,
  parameter int OUT_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CH_W-1:0]   cfg_num_ch,
  input  logic [OUT_W-1:0]  cfg_num_out,
  output logic              busy,
  output logic              done,
  input  logic              in_vld,
  output logic              in_rdy,
  output logic              tree_vld_i,
  input  logic              tree_vld_o,
  input  logic [TREE_W-1:0] tree_acc,
  output logic              out_vld,
  input  logic              out_rdy,
  output logic [ACC_W-1:0]  out_data,
  output logic              out_last
);
  localparam int GW = $clog2(OUT_DEPTH + 1);

  if (!acc_w_ok(ACC_W, CH_W) || TREE_LAT < 1) begin : g_bad_cfg
    $error("conv_acc_sched: ACC_W too narrow for CH_W, or TREE_LAT < 1");
  end

  state_e            state_q, state_d;
  logic [CH_W-1:0]   nch_q, nch_d, ch_cnt_q, ch_cnt_d, rcv_q, rcv_d;
  logic [OUT_W-1:0]  nout_q, nout_d, pix_iss_q, pix_iss_d, pix_done_q, pix_done_d;
  logic [GW-1:0]     grp_q, grp_d;
  logic [ACC_W-1:0]  acc_q, acc_d;
  logic              done_q, done_d;

  logic              launch, grp_start, ch_last, rcv_en, rcv_last, push, pop;
  logic              fifo_full, fifo_empty, grp_full;
  logic [OUT_W-1:0]  pix_iss_nxt;
  logic [ACC_W-1:0]  tree_sx, rcv_sum;
  logic [ACC_W:0]    fifo_wdata, fifo_rdata;

  // A new group may only start while a FIFO slot is reserved for it; the tree cannot stall.
  assign grp_full   = (grp_q == GW'(OUT_DEPTH)) | fifo_full;
  assign in_rdy     = (state_q == ST_RUN) && !(ch_cnt_q == '0 && grp_full);
  assign launch     = in_vld & in_rdy;
  assign tree_vld_i = launch;
  assign grp_start  = launch & (ch_cnt_q == '0);
  assign ch_last    = (ch_cnt_q == nch_q - CH_W'(1));
  assign pix_iss_nxt = grp_start ? pix_iss_q + OUT_W'(1) : pix_iss_q;

  assign tree_sx    = {{(ACC_W-TREE_W){tree_acc[TREE_W-1]}}, tree_acc};
  assign rcv_en     = tree_vld_o & (state_q != ST_IDLE);
  assign rcv_last   = (rcv_q == nch_q - CH_W'(1));
  assign rcv_sum    = ((rcv_q == '0) ? '0 : acc_q) + tree_sx;
  assign push       = rcv_en & rcv_last;
  assign fifo_wdata = {(pix_done_q == nout_q - OUT_W'(1)), rcv_sum};

  assign out_vld    = ~fifo_empty;
  assign {out_last, out_data} = fifo_rdata;
  assign pop        = out_vld & out_rdy;
  assign busy       = (state_q != ST_IDLE);
  assign done       = done_q | ((state_q == ST_DRAIN) & pop & out_last);

  always_comb begin
    state_d    = state_q;
    nch_d      = nch_q;
    nout_d     = nout_q;
    ch_cnt_d   = ch_cnt_q;
    pix_iss_d  = pix_iss_q;
    grp_d      = grp_q + GW'(grp_start) - GW'(pop);
    rcv_d      = rcv_q;
    pix_done_d = pix_done_q;
    acc_d      = acc_q;
    done_d     = 1'b0;

    if (launch) begin
      ch_cnt_d  = ch_last ? '0 : ch_cnt_q + CH_W'(1);
      pix_iss_d = pix_iss_nxt;
    end
    if (rcv_en) begin
      if (rcv_last) begin
        rcv_d      = '0;
        pix_done_d = pix_done_q + OUT_W'(1);
      end else begin
        rcv_d = rcv_q + CH_W'(1);
        acc_d = rcv_sum;
      end
    end

    case (state_q)
      ST_IDLE: if (start) begin
        if (cfg_num_ch == '0 || cfg_num_out == '0) begin
          done_d = 1'b1;
        end else begin
          nch_d      = cfg_num_ch;
          nout_d     = cfg_num_out;
          ch_cnt_d   = '0;
          pix_iss_d  = '0;
          grp_d      = '0;
          rcv_d      = '0;
          pix_done_d = '0;
          acc_d      = '0;
          state_d    = ST_RUN;
        end
      end
      ST_RUN:   if (launch && ch_last && pix_iss_nxt == nout_q) state_d = ST_DRAIN;
      ST_DRAIN: if (pop && out_last) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      nch_q      <= '0;
      nout_q     <= '0;
      ch_cnt_q   <= '0;
      pix_iss_q  <= '0;
      grp_q      <= '0;
      rcv_q      <= '0;
      pix_done_q <= '0;
      acc_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      nch_q      <= nch_d;
      nout_q     <= nout_d;
      ch_cnt_q   <= ch_cnt_d;
      pix_iss_q  <= pix_iss_d;
      grp_q      <= grp_d;
      rcv_q      <= rcv_d;
      pix_done_q <= pix_done_d;
      acc_q      <= acc_d;
      done_q     <= done_d;
    end
  end

  acc_out_fifo #(.W(ACC_W + 1), .DEPTH(OUT_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .wdata_i (fifo_wdata),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );
endmodule

// File: tb/tb_conv_acc_sched.sv
// Randomised bench: behavioural tree delay line plus per-pixel sum scoreboard.
module tb_conv_acc_sched;
  localparam int TREE_LAT = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic [7:0]  cfg_num_ch = '0;
  logic [15:0] cfg_num_out = '0;
  logic        busy, done, in_rdy, tree_vld_i, out_vld, out_last;
  logic        in_vld = 1'b0;
  logic        out_rdy = 1'b0;
  logic        tree_vld_o;
  logic [19:0] tree_acc;
  logic [31:0] out_data;
  logic [19:0] prod = '0;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int vals[$];

  conv_acc_sched #(.TREE_LAT(TREE_LAT), .CH_W(8), .OUT_W(16), .ACC_W(32), .OUT_DEPTH(2)) dut (
    .clk(clk), .rst(rst), .start(start), .cfg_num_ch(cfg_num_ch), .cfg_num_out(cfg_num_out),
    .busy(busy), .done(done), .in_vld(in_vld), .in_rdy(in_rdy), .tree_vld_i(tree_vld_i),
    .tree_vld_o(tree_vld_o), .tree_acc(tree_acc), .out_vld(out_vld), .out_rdy(out_rdy),
    .out_data(out_data), .out_last(out_last)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Adder tree stand-in: the launched product reappears TREE_LAT cycles later.
  logic [TREE_LAT-1:0] tv;
  logic [19:0]         td [TREE_LAT];
  always @(posedge clk) begin
    if (rst) tv <= '0;
    else     tv <= {tv[TREE_LAT-2:0], tree_vld_i};
    td[0] <= prod;
    for (int i = 1; i < TREE_LAT; i++) td[i] <= td[i-1];
  end
  assign tree_vld_o = tv[TREE_LAT-1];
  assign tree_acc   = td[TREE_LAT-1];

  task automatic chk(input string tag, input longint got, input longint exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  task automatic fill_rand(input int n);
    vals.delete();
    for (int i = 0; i < n; i++) vals.push_back(int'($urandom_range(1048575)) - 524288);
  endtask

  task automatic run_job(input int nch, input int nout, input int vld_pct, input int rdy_pct,
                         input int hold, input int exp_stall, input bit timing, input bit glitch);
    longint exp_d[$];
    longint s;
    int k, pops, budget, l_first, l_last, l_grp, first_vld, bad_tv, bad_done;
    for (int p = 0; p < nout; p++) begin
      s = 0;
      for (int c = 0; c < nch; c++) s += vals[p*nch + c];
      exp_d.push_back(s);
    end
    @(posedge clk); #1;
    start = 1'b1; cfg_num_ch = 8'(nch); cfg_num_out = 16'(nout);
    in_vld = 1'b0; out_rdy = 1'b0;
    k = 0; pops = 0; budget = 0; l_first = -1; l_last = -1; l_grp = -1;
    first_vld = -1; bad_tv = 0; bad_done = 0;
    while (pops < nout && budget < 20000) begin
      @(negedge clk);
      if (tree_vld_i !== (in_vld && in_rdy)) bad_tv++;
      if (in_vld && in_rdy) begin
        if (k == 0) l_first = cyc;
        if (k == nch - 1) l_grp = cyc;
        l_last = cyc;
        k++;
      end
      if (out_vld && first_vld < 0) first_vld = cyc;
      if (out_vld && out_rdy) begin
        chk("out_data", longint'($signed(out_data)), exp_d[pops]);
        chk("out_last", longint'(out_last), longint'(pops == nout - 1));
        if (pops == nout - 1) chk("done_on_last_pop", longint'(done), 1);
        pops++;
      end else if (done) bad_done++;
      if (budget == hold && exp_stall >= 0) begin
        chk("stall_launches", k, exp_stall);
        chk("stall_in_rdy", longint'(in_rdy), 0);
      end
      budget++;
      @(posedge clk); #1;
      start       = glitch && (budget == 3);
      cfg_num_ch  = glitch ? 8'd7 : 8'(nch);
      in_vld      = (k < nch*nout) && ($urandom_range(99) < vld_pct);
      prod        = (k < vals.size()) ? 20'(vals[k]) : 20'd0;
      out_rdy     = (budget > hold) && ($urandom_range(99) < rdy_pct);
    end
    chk("timeout", longint'(budget >= 20000), 0);
    chk("launch_count", k, nch*nout);
    chk("tree_vld_i_eq", bad_tv, 0);
    chk("stray_done", bad_done, 0);
    if (timing) begin
      chk("launch_span", l_last - l_first, nch*nout - 1);
      chk("result_latency", first_vld - l_grp, TREE_LAT + 1);
    end
    start = 1'b0; in_vld = 1'b0; out_rdy = 1'b0;
    @(negedge clk);
    chk("idle_busy", longint'(busy), 0);
  endtask

  initial begin
    int w;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_done", longint'(done), 0);
    chk("rst_in_rdy", longint'(in_rdy), 0);
    chk("rst_tree_vld_i", longint'(tree_vld_i), 0);
    chk("rst_out_vld", longint'(out_vld), 0);
    chk("rst_out_last", longint'(out_last), 0);
    chk("rst_out_data", longint'(out_data), 0);
    @(posedge clk); #1; rst = 1'b0;

    vals = '{1, 2, 3, -4, 5, -6};
    run_job(3, 2, 100, 100, 0, -1, 1'b1, 1'b0);

    fill_rand(4);
    run_job(1, 4, 100, 100, 20, 2, 1'b0, 1'b0);

    vals.delete();
    for (int i = 0; i < 255; i++) vals.push_back(-524288);
    run_job(255, 1, 100, 100, 0, -1, 1'b0, 1'b0);

    fill_rand(16);
    run_job(2, 8, 100, 50, 0, -1, 1'b0, 1'b0);

    @(posedge clk); #1; start = 1'b1; cfg_num_ch = 8'd3; cfg_num_out = 16'd0;
    @(negedge clk);
    chk("zero_cfg_busy", longint'(busy), 0);
    @(posedge clk); #1; start = 1'b0;
    @(negedge clk);
    chk("zero_cfg_done", longint'(done), 1);
    chk("zero_cfg_busy2", longint'(busy), 0);
    @(negedge clk);
    chk("zero_cfg_done_pulse", longint'(done), 0);

    fill_rand(12);
    run_job(3, 4, 80, 80, 0, -1, 1'b0, 1'b1);

    fill_rand(4);
    @(posedge clk); #1;
    start = 1'b1; cfg_num_ch = 8'd1; cfg_num_out = 16'd4; out_rdy = 1'b0;
    @(posedge clk); #1;
    start = 1'b0; in_vld = 1'b1; prod = 20'(vals[0]);
    w = 0;
    while (!out_vld && w < 50) begin @(negedge clk); w++; end
    chk("mid_rst_wait", longint'(w >= 50), 0);
    @(posedge clk); #1; rst = 1'b1; in_vld = 1'b0;
    @(posedge clk); #1; rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_out_vld", longint'(out_vld), 0);
    chk("mid_rst_busy", longint'(busy), 0);
    chk("mid_rst_in_rdy", longint'(in_rdy), 0);
    chk("mid_rst_done", longint'(done), 0);

    for (int j = 0; j < 6; j++) begin
      int nch, nout;
      nch  = int'($urandom_range(1, 6));
      nout = int'($urandom_range(1, 6));
      fill_rand(nch*nout);
      run_job(nch, nout, 60, 60, 0, -1, 1'b0, 1'b0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
